matmul_stream_host: RTL
=======================

Name: matmul_stream_host

Overview:
Initiator for the 3-element nibble-stream matrix-multiply engine. It accepts a parallel 3-element vector through a start/busy handshake and serialises it onto the engine's `in_en`/`datain` input. It then collects the engine's 3-word `multout`/`valid` result burst into a parallel result register and reports completion or a protocol error. It sits between a register/control front end and the matrix-multiply engine.

Parameters:
DW, 4, width of one input element (engine `datain` width)
OW, 10, width of one result word (engine `multout` width)
TIMEOUT, 15, maximum cycles spent in WAIT for the first `mm_valid` before error; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
vec_in  input  3*DW  elements e0=[DW-1:0], e1=[2DW-1:DW], e2=[3DW-1:2DW]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse, result valid on res_out
res_out  output  3*OW  r0=[OW-1:0], r1=[2OW-1:OW], r2=[3OW-1:2OW]
err  output  1  high when err_code != 0
err_code  output  2  00 none, 01 timeout, 10 truncated burst
mm_in_en  output  1  to engine in_en
mm_datain  output  DW  to engine datain
mm_multout  input  OW  from engine multout
mm_valid  input  1  from engine valid

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all counters 0; vec latch, shadow and res_out = 0.
  - err_code=00; done=0; busy=0; mm_in_en=0; mm_datain=0.
- State IDLE:
  - busy=0.
  - If start=1 at a rising edge: latch vec_in, clear err_code to 00, set cnt=0, go to SEND.
- State SEND (exactly 3 cycles):
  - mm_in_en=1; mm_datain = latched element[cnt]; cnt increments each cycle.
  - When cnt==2, the next state is WAIT; cnt and tmo are cleared.
  - mm_in_en and mm_datain are decoded combinationally from the registered state and cnt. Outside SEND both are 0.
- State WAIT:
  - tmo increments each cycle.
  - If mm_valid=1: shadow[0] <= mm_multout, rcnt=1, go to RECV.
  - Else if tmo==TIMEOUT-1: err_code <= 01, go to IDLE. No done pulse; res_out unchanged.
- State RECV:
  - If mm_valid=1: shadow[rcnt] <= mm_multout. When rcnt==2, go to DONE; otherwise rcnt increments.
  - If mm_valid=0: err_code <= 10, go to IDLE. res_out unchanged.
- State DONE (1 cycle):
  - done=1, busy=1.
  - res_out was loaded from shadow on entry to DONE, so res_out is valid in the same cycle done=1.
  - Next state is IDLE.
- res_out holds its value until the next successful DONE.
- err_code holds until the next accepted start or reset.
- start outside IDLE is ignored and not queued. start held high continuously re-triggers from IDLE, one transaction per IDLE visit.
- mm_valid is ignored in IDLE, SEND and DONE, and never counts toward a burst.
- Latency:
  - start edge at cycle T gives mm_in_en high in T+1..T+3.
  - done asserts 1 cycle after the edge that captures the third word.
  - Minimum start-to-done latency is 7 cycles (first valid in the first WAIT cycle).
- Arithmetic: none. Counters are 2-bit (cnt, rcnt); tmo is 8-bit. No wrap occurs within legal TIMEOUT.

Test Plan:
1. Reset: hold rst=0 with random inputs -> busy=0, done=0, mm_in_en=0, mm_datain=0, res_out=0, err_code=00. Assert rst=0 asynchronously mid-clock -> outputs clear immediately.
2. Nominal: vec_in e0=1, e1=2, e2=3, start pulse; model returns 13, 9, 11 on 3 consecutive valid cycles starting 2 cycles after mm_in_en falls -> mm_datain sequence 1, 2, 3 with mm_in_en high exactly 3 cycles; done one cycle; res_out r0=13, r1=9, r2=11; err_code=00; busy falls the cycle after done.
3. Timeout: TIMEOUT=15, model never asserts valid -> IDLE after exactly 15 WAIT cycles; err_code=01; no done; res_out keeps the previous result.
4. Truncated burst: valid for 2 cycles then low -> err_code=10; no done; res_out unchanged. A following good transaction clears err_code to 00 and completes.
5. Handshake: start pulsed during SEND/WAIT/RECV/DONE -> ignored, exactly one transaction. Spurious mm_valid during SEND -> ignored, correct result. start held high -> back-to-back transactions, each with one done pulse.
6. Reset during RECV after 1 captured word -> immediate IDLE, res_out=0, done never pulses. Next transaction runs normally.

Source files
------------

// File: rtl/matmul_stream_host.sv
`default_nettype none
// ============================================================================
// Module      : matmul_stream_host
// Description : Initiator for the 3-element nibble-stream matrix-multiply
//               engine. Serialises a parallel vector onto in_en/datain,
//               collects the 3-word valid burst into res_out, and flags
//               timeout / truncated-burst errors.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_stream_host #(
    parameter int DW      = 4,
    parameter int OW      = 10,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3*DW-1:0] vec_in,
    output logic            busy,
    output logic            done,
    output logic [3*OW-1:0] res_out,
    output logic            err,
    output logic [1:0]      err_code,
    output logic            mm_in_en,
    output logic [DW-1:0]   mm_datain,
    input  logic [OW-1:0]   mm_multout,
    input  logic            mm_valid
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        WAIT = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      cnt;
    logic [1:0]      rcnt;
    logic [7:0]      tmo;
    logic [3*DW-1:0] vec_q;
    logic [OW-1:0]   shadow0;
    logic [OW-1:0]   shadow1;

    assign err = |err_code;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs (engine strobe/data, busy, done).
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        mm_in_en  = 1'b0;
        mm_datain = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                mm_in_en = 1'b1;
                case (cnt)
                    2'd0:    mm_datain = vec_q[DW-1:0];
                    2'd1:    mm_datain = vec_q[2*DW-1:DW];
                    default: mm_datain = vec_q[3*DW-1:2*DW];
                endcase
                if (cnt == 2'd2) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (mm_valid) begin
                    state_nxt = RECV;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = IDLE;
                end
            end
            RECV: begin
                if (!mm_valid) begin
                    state_nxt = IDLE;
                end else if (rcnt == 2'd2) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: vector latch, counters, result capture and error code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 2'd0;
            rcnt     <= 2'd0;
            tmo      <= 8'd0;
            vec_q    <= '0;
            shadow0  <= '0;
            shadow1  <= '0;
            res_out  <= '0;
            err_code <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_q    <= vec_in;
                        err_code <= 2'b00;
                        cnt      <= 2'd0;
                    end
                end
                SEND: begin
                    if (cnt == 2'd2) begin
                        cnt <= 2'd0;
                        tmo <= 8'd0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                WAIT: begin
                    tmo <= tmo + 8'd1;
                    if (mm_valid) begin
                        shadow0 <= mm_multout;
                        rcnt    <= 2'd1;
                    end else if (tmo == TMO_LAST) begin
                        err_code <= 2'b01;
                    end
                end
                RECV: begin
                    if (!mm_valid) begin
                        err_code <= 2'b10;
                    end else if (rcnt == 2'd2) begin
                        // Third word goes straight into the result so res_out
                        // is already valid during the done cycle.
                        res_out <= {mm_multout, shadow1, shadow0};
                    end else begin
                        // rcnt can only be 1 here: second word of the burst.
                        shadow1 <= mm_multout;
                        rcnt    <= rcnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
